// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Opcode and FSM state encodings shared by the multicycle CPU.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_LDI  = 3'b100,
        OP_BNZ  = 3'b101,
        OP_NOP  = 3'b110,
        OP_HALT = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    function automatic logic writes_reg(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_LDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : Register file, three asynchronous reads, one synchronous write.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RA_W-1:0]   rd_addr1,
    input  logic [RA_W-1:0]   rd_addr2,
    input  logic [RA_W-1:0]   rd_addr3,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] rd_data3,
    input  logic              wr_en,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int NREG = 2**RA_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    assign rd_data1 = regs_q[rd_addr1];
    assign rd_data2 = regs_q[rd_addr2];
    assign rd_data3 = regs_q[rd_addr3];

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_cpu
//  Description : Four-cycle-per-instruction CPU: FSM, IR, PC and ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RA_W   = 2,
    parameter int PC_W   = 4,
    localparam int INST_W = 3 + 3*RA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] inst_out,
    output logic [DATA_W-1:0] mem_data,
    output logic              wb_valid,
    output logic              zero,
    output logic              halted
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INST_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d, opd_q, opd_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                wb_valid_q, wb_valid_d;
    logic                zero_q, zero_d;

    op_e                 w_op;
    logic [RA_W-1:0]     w_dest, w_src1, w_src2;
    logic [2*RA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_rd_src1, w_rd_src2, w_rd_dest;
    logic                w_rf_we;

    assign w_op   = op_e'(ir_q[INST_W-1 -: 3]);
    assign w_dest = ir_q[3*RA_W-1 -: RA_W];
    assign w_src1 = ir_q[2*RA_W-1 -: RA_W];
    assign w_src2 = ir_q[RA_W-1:0];
    assign w_imm  = {w_src1, w_src2};

    reg_file #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_rf (
        .clk      (clk),
        .rst_n    (reset),
        .rd_addr1 (w_src1),
        .rd_addr2 (w_src2),
        .rd_addr3 (w_dest),
        .rd_data1 (w_rd_src1),
        .rd_data2 (w_rd_src2),
        .rd_data3 (w_rd_dest),
        .wr_en    (w_rf_we),
        .wr_addr  (w_dest),
        .wr_data  (result_q)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        opd_d      = opd_q;
        result_d   = result_q;
        mem_data_d = mem_data_q;
        wb_valid_d = 1'b0;
        zero_d     = zero_q;
        w_rf_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = imem_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // dest is latched too: BNZ tests it, not the ALU result
                opa_d   = w_rd_src1;
                opb_d   = w_rd_src2;
                opd_d   = w_rd_dest;
                state_d = (w_op == OP_HALT) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (w_op)
                    OP_ADD:  result_d = opa_q + opb_q;
                    OP_SUB:  result_d = opa_q - opb_q;
                    OP_AND:  result_d = opa_q & opb_q;
                    OP_OR:   result_d = opa_q | opb_q;
                    OP_LDI:  result_d = DATA_W'(w_imm);
                    default: result_d = result_q;
                endcase
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                pc_d = pc_q + PC_W'(1);
                if (writes_reg(w_op)) begin
                    w_rf_we    = 1'b1;
                    mem_data_d = result_q;
                    wb_valid_d = 1'b1;
                    zero_d     = (result_q == '0);
                end else if ((w_op == OP_BNZ) && (opd_q != '0)) begin
                    pc_d = PC_W'(w_imm);
                end
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            opd_q      <= '0;
            result_q   <= '0;
            mem_data_q <= '0;
            wb_valid_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            opd_q      <= opd_d;
            result_q   <= result_d;
            mem_data_q <= mem_data_d;
            wb_valid_q <= wb_valid_d;
            zero_q     <= zero_d;
        end
    end

    assign imem_addr = pc_q;
    assign inst_out  = ir_q;
    assign mem_data  = mem_data_q;
    assign wb_valid  = wb_valid_q;
    assign zero      = zero_q;
    assign halted    = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_cpu
//  Description : Self-checking bench with a writeback scoreboard and ALU table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_cpu;

    localparam int DATA_W = 8;
    localparam int RA_W   = 2;
    localparam int PC_W   = 4;
    localparam int INST_W = 9;

    localparam logic [INST_W-1:0] I_NOP  = 9'b110_00_00_00;
    localparam logic [INST_W-1:0] I_HALT = 9'b111_00_00_00;

    logic              clk;
    logic              reset;
    logic              run;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;
    logic [INST_W-1:0] inst_out;
    logic [DATA_W-1:0] mem_data;
    logic              wb_valid;
    logic              zero;
    logic              halted;

    logic [INST_W-1:0] imem [16];
    assign imem_data = imem[imem_addr];

    multicycle_cpu #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W),
        .PC_W   (PC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .inst_out  (inst_out),
        .mem_data  (mem_data),
        .wb_valid  (wb_valid),
        .zero      (zero),
        .halted    (halted)
    );

    typedef struct {
        logic [7:0] data;
        logic       z;
    } wb_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    wb_t  sb[$];
    int   wb_cycles[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   start_cyc = 0;
    vec_t vecs [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every writeback pulse must match the oldest expectation
    always @(negedge clk) begin
        if (reset && wb_valid) begin
            wb_cycles.push_back(cyc - start_cyc);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: got writeback %0h expected none", mem_data);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_data", {24'd0, mem_data}, {24'd0, e.data});
                chk("wb_zero", {31'd0, zero}, {31'd0, e.z});
            end
        end
    end

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [1:0] d,
                                       input logic [1:0] s1, input logic [1:0] s2);
        return {op, d, s1, s2};
    endfunction

    function automatic logic [8:0] ldi(input logic [1:0] d, input logic [3:0] imm);
        return {3'b100, d, imm};
    endfunction

    task automatic expect_wb(input logic [7:0] d);
        wb_t e;
        e.data = d;
        e.z    = (d == 8'd0);
        sb.push_back(e);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) imem[i] = I_NOP;
    endtask

    task automatic load_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        fill_nop();
        imem[0] = ldi(2'd1, a);
        imem[1] = ldi(2'd2, b);
        imem[2] = enc(op, 2'd3, 2'd1, 2'd2);
        imem[3] = I_HALT;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        wb_cycles.delete();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_run();
        wb_cycles.delete();
        start_cyc = cyc;
        run       = 1'b1;
    endtask

    task automatic wait_halt(input int bound, input string name);
        for (int i = 0; i < bound && !halted; i++) @(negedge clk);
        chk(name, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{3'b000, 4'd5,  4'd3,  8'h08};
        vecs[1] = '{3'b000, 4'd15, 4'd15, 8'h1E};
        vecs[2] = '{3'b001, 4'd3,  4'd5,  8'hFE};
        vecs[3] = '{3'b001, 4'd7,  4'd7,  8'h00};
        vecs[4] = '{3'b010, 4'd12, 4'd10, 8'h08};
        vecs[5] = '{3'b010, 4'd5,  4'd10, 8'h00};
        vecs[6] = '{3'b011, 4'd12, 4'd3,  8'h0F};
        vecs[7] = '{3'b011, 4'd0,  4'd0,  8'h00};

        // Reset held with run high
        load_alu(3'b000, 4'd5, 4'd3);
        reset = 1'b0;
        run   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pc",       {28'd0, imem_addr}, 32'd0);
        chk("rst_inst",     {23'd0, inst_out},  32'd0);
        chk("rst_mem_data", {24'd0, mem_data},  32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid},  32'd0);
        chk("rst_halted",   {31'd0, halted},    32'd0);
        chk("rst_zero",     {31'd0, zero},      32'd0);
        run   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_pc",   {28'd0, imem_addr}, 32'd0);
        chk("idle_inst", {23'd0, inst_out},  32'd0);

        // Arithmetic program with writeback timing
        start_run();
        expect_wb(8'd5);
        expect_wb(8'd3);
        expect_wb(8'd8);
        wait_halt(80, "arith_halt");
        chk("arith_wb_count", wb_cycles.size(), 32'd3);
        if (wb_cycles.size() == 3) begin
            chk("arith_wb_cyc0", wb_cycles[0], 32'd5);
            chk("arith_wb_cyc1", wb_cycles[1], 32'd9);
            chk("arith_wb_cyc2", wb_cycles[2], 32'd13);
        end
        chk("arith_mem_data", {24'd0, mem_data}, 32'd8);
        chk("arith_pc",       {28'd0, imem_addr}, 32'd3);
        chk("arith_sb_empty", sb.size(), 32'd0);
        repeat (10) @(negedge clk);
        chk("halt_absorb",    {31'd0, halted},    32'd1);
        chk("halt_pc_hold",   {28'd0, imem_addr}, 32'd3);
        chk("halt_ir_hold",   {23'd0, inst_out},  {23'd0, I_HALT});

        // ALU vector table
        for (int v = 0; v < 8; v++) begin
            do_reset();
            load_alu(vecs[v].op, vecs[v].a, vecs[v].b);
            start_run();
            expect_wb({4'd0, vecs[v].a});
            expect_wb({4'd0, vecs[v].b});
            expect_wb(vecs[v].exp);
            wait_halt(80, "vec_halt");
            chk("vec_r3", {24'd0, dut.u_rf.regs_q[3]}, {24'd0, vecs[v].exp});
            chk("vec_sb_empty", sb.size(), 32'd0);
        end

        // SUB wrap then zero flag
        do_reset();
        fill_nop();
        imem[0] = ldi(2'd1, 4'd5);
        imem[1] = ldi(2'd2, 4'd3);
        imem[2] = enc(3'b001, 2'd0, 2'd2, 2'd1);
        imem[3] = enc(3'b001, 2'd0, 2'd1, 2'd1);
        imem[4] = I_HALT;
        start_run();
        expect_wb(8'd5);
        expect_wb(8'd3);
        expect_wb(8'hFE);
        expect_wb(8'h00);
        wait_halt(100, "wrap_halt");
        chk("wrap_zero",     {31'd0, zero},     32'd1);
        chk("wrap_mem_data", {24'd0, mem_data}, 32'd0);
        chk("wrap_sb_empty", sb.size(),         32'd0);

        // Branch loop: SUB runs three times
        do_reset();
        fill_nop();
        imem[0] = ldi(2'd1, 4'd3);
        imem[1] = ldi(2'd2, 4'd1);
        imem[2] = enc(3'b001, 2'd1, 2'd1, 2'd2);
        imem[3] = enc(3'b101, 2'd1, 2'd0, 2'd2);
        imem[4] = I_HALT;
        start_run();
        expect_wb(8'd3);
        expect_wb(8'd1);
        expect_wb(8'd2);
        expect_wb(8'd1);
        expect_wb(8'd0);
        wait_halt(200, "loop_halt");
        chk("loop_r1",       {24'd0, dut.u_rf.regs_q[1]}, 32'd0);
        chk("loop_pc",       {28'd0, imem_addr},          32'd4);
        chk("loop_wb_count", wb_cycles.size(),            32'd5);
        chk("loop_sb_empty", sb.size(),                   32'd0);

        // Asynchronous reset during EXECUTE of ADD
        do_reset();
        load_alu(3'b000, 4'd5, 4'd3);
        start_run();
        expect_wb(8'd5);
        expect_wb(8'd3);
        repeat (11) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_pc",       {28'd0, imem_addr}, 32'd0);
        chk("async_inst",     {23'd0, inst_out},  32'd0);
        chk("async_mem_data", {24'd0, mem_data},  32'd0);
        chk("async_wb_valid", {31'd0, wb_valid},  32'd0);
        chk("async_zero",     {31'd0, zero},      32'd0);
        chk("async_r1",       {24'd0, dut.u_rf.regs_q[1]}, 32'd0);
        chk("async_sb_empty", sb.size(),          32'd0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("async_idle_pc", {28'd0, imem_addr}, 32'd0);
        start_run();
        expect_wb(8'd5);
        expect_wb(8'd3);
        expect_wb(8'd8);
        wait_halt(80, "async_rerun_halt");
        chk("async_rerun_pc", {28'd0, imem_addr}, 32'd3);
        if (wb_cycles.size() > 0) chk("async_first_wb_cyc", wb_cycles[0], 32'd5);
        chk("async_rerun_sb_empty", sb.size(), 32'd0);

        // PC wrap over sixteen NOPs
        do_reset();
        fill_nop();
        start_run();
        repeat (61) @(posedge clk);
        #1;
        chk("wrap_pc15", {28'd0, imem_addr}, 32'd15);
        repeat (4) @(posedge clk);
        #1;
        chk("wrap_pc0",      {28'd0, imem_addr}, 32'd0);
        chk("nop_no_wb",     wb_cycles.size(),   32'd0);

        // Run dropped during DECODE
        do_reset();
        fill_nop();
        start_run();
        repeat (2) @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("gate_pc_mid",  {28'd0, imem_addr}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("gate_pc_done", {28'd0, imem_addr}, 32'd1);
        chk("gate_ir",      {23'd0, inst_out},  {23'd0, I_NOP});
        chk("gate_halted",  {31'd0, halted},    32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning the datapath and register width in bits.
REQ-002 The module SHALL have parameter RA_W, default 2, meaning the register address width; it gives 2**RA_W registers.
REQ-003 The module SHALL have parameter PC_W, default 4, meaning the program counter width; it gives a program depth of 2**PC_W.
REQ-004 The module SHALL have derived localparam INST_W = 3 + 3*RA_W (default 9).
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port run, input, 1 bit: level enable that starts and continues instruction execution.
REQ-008 The module SHALL have port imem_addr, output, PC_W bits: instruction memory address, always equal to pc.
REQ-009 The module SHALL have port imem_data, input, INST_W bits: instruction word; it is combinational from imem_addr.
REQ-010 The module SHALL have port inst_out, output, INST_W bits: the currently held instruction register (IR).
REQ-011 The module SHALL have port mem_data, output, DATA_W bits: the last value written back to the register file.
REQ-012 The module SHALL have port wb_valid, output, 1 bit: a one-cycle pulse when a register write occurs.
REQ-013 The module SHALL have port zero, output, 1 bit: set to (result == 0) at each ALU writeback.
REQ-014 The module SHALL have port halted, output, 1 bit: high while the FSM is in HALT.

Function
REQ-015 The IR SHALL be decoded as follows: op = IR[INST_W-1 -: 3], dest = next RA_W bits, src1 = next RA_W bits, src2 = low RA_W bits.
REQ-016 The opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LDI, 101 BNZ, 110 NOP, 111 HALT.
REQ-017 The FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE, WRITEBACK and HALT; each non-HALT instruction takes exactly 4 cycles (FETCH through WRITEBACK).
REQ-018 The FSM SHALL move from IDLE to FETCH when run=1, and remain in IDLE otherwise.
REQ-019 In FETCH, the FSM SHALL latch imem_data into the IR.
REQ-020 In DECODE, the FSM SHALL read R[src1], R[src2] and R[dest] into operand latches, and SHALL go to HALT if op=HALT.
REQ-021 In EXECUTE, the FSM SHALL compute the result.
- ALU results are taken modulo 2**DATA_W; SUB wraps, with no carry or borrow output.
- LDI loads {src1,src2} zero-extended to DATA_W.
REQ-022 In WRITEBACK, the FSM SHALL update registers and the PC.
- ADD/SUB/AND/OR/LDI: R[dest] <= result; mem_data <= result; wb_valid=1 for this cycle only.
- BNZ: if the latched R[dest] != 0 then pc <= {src1,src2} truncated or zero-extended to PC_W; otherwise pc <= pc+1.
- All other opcodes: pc <= pc+1, modulo 2**PC_W (15 wraps to 0 by default).
REQ-023 After WRITEBACK, the FSM SHALL go to FETCH if run=1, else to IDLE; dropping run mid-instruction never aborts that instruction.
REQ-024 Operands SHALL be read in DECODE, so an instruction with dest==src reads the pre-write value; no register is hardwired to zero.
REQ-025 zero SHALL update only on ALU/LDI writeback and SHALL hold otherwise.
REQ-026 HALT SHALL be absorbing: pc and IR hold, halted=1, run is ignored, and only reset exits it.

Reset
REQ-027 On reset=0, the block SHALL immediately (asynchronously) set state=IDLE, pc=0, IR=0, all registers=0, mem_data=0, wb_valid=0, zero=0 and halted=0, including when reset asserts mid-instruction.
REQ-028 After reset deasserts, the block SHALL begin from IDLE and fetch pc=0 on the first cycle in which run=1.

Structure
REQ-029 Opcode constants and the FSM state enum SHALL live in a shared package cpu_pkg.
REQ-030 The register file SHALL be one sub-module, reg_file, parameterised by DATA_W and RA_W, with three asynchronous read ports and one synchronous write port, and cleared by the same asynchronous reset.
REQ-031 The FSM, IR, PC and ALU SHALL reside in multicycle_cpu itself.

Verification
REQ-032 Reset: hold reset=0 for 3 cycles with run=1 -> pc=0, inst_out=0, mem_data=0, wb_valid=0, halted=0, zero=0.
REQ-033 Arithmetic: program LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT with run=1 -> wb_valid pulses at cycles 5, 9 and 13 after run rises, mem_data ends at 8, then halted=1 with pc=3.
REQ-034 Wrap and zero: LDI r1,5; LDI r2,3; SUB r0,r2,r1 -> mem_data=0xFE and zero=0; then SUB r0,r1,r1 -> mem_data=0 and zero=1.
REQ-035 Branch loop: LDI r1,3; LDI r2,1; SUB r1,r1,r2; BNZ r1,2; HALT -> the SUB executes 3 times and final R1=0, then halted=1 at pc=4.
REQ-036 Async reset mid-op: assert reset during EXECUTE of ADD -> outputs clear in the same cycle with no writeback; after release and run=1, the fetch starts at pc=0.
REQ-037 PC wrap and run gating: with 16 NOPs, pc goes 15 -> 0; with run dropped during DECODE, the instruction completes, the FSM enters IDLE, and pc holds at pc+1.
